cga_rgb_decoder: RTL and testbench

//  Inverse of the CGA 16-colour palette stage: takes 6/7/6-bit RGB pixel samples and

---
 rtl/cga_rgb_decoder.sv | 150 +++++++++++++++
 tb/tb_cga_rgb_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_rgb_decoder.sv
// Classifies 6/7/6-bit RGB samples as the nearest CGA IRGB palette index.
// Three-stage valid/ready pipeline with exact-hit flag and a saturating miss counter.
module cga_rgb_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       red,
  input  logic [6:0]       green,
  input  logic [5:0]       blue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       video,
  output logic             exact,
  output logic [CNT_W-1:0] miss_count,
  input  logic             miss_clear
);

  localparam logic [5:0] LV_L  = 6'd0;
  localparam logic [5:0] LV_LO = 6'd21;
  localparam logic [5:0] LV_H  = 6'd42;
  localparam logic [5:0] LV_F  = 6'd63;

  // Palette entry k as {R, G, B} 6-bit levels; index 6 is brown (half green).
  function automatic logic [17:0] pal_rgb(input int k);
    logic [17:0] v;
    case (k)
      0:       v = {LV_L,  LV_L,  LV_L };
      1:       v = {LV_L,  LV_L,  LV_H };
      2:       v = {LV_L,  LV_H,  LV_L };
      3:       v = {LV_L,  LV_H,  LV_H };
      4:       v = {LV_H,  LV_L,  LV_L };
      5:       v = {LV_H,  LV_L,  LV_H };
      6:       v = {LV_H,  LV_LO, LV_L };
      7:       v = {LV_H,  LV_H,  LV_H };
      8:       v = {LV_LO, LV_LO, LV_LO};
      9:       v = {LV_LO, LV_LO, LV_F };
      10:      v = {LV_LO, LV_F,  LV_LO};
      11:      v = {LV_LO, LV_F,  LV_F };
      12:      v = {LV_F,  LV_LO, LV_LO};
      13:      v = {LV_F,  LV_LO, LV_F };
      14:      v = {LV_F,  LV_F,  LV_LO};
      default: v = {LV_F,  LV_F,  LV_F };
    endcase
    return v;
  endfunction

  logic                w_en;
  logic                w_unused_green_lsb;
  logic                r_s1_valid;
  logic [5:0]          r_s1_r;
  logic [5:0]          r_s1_g;
  logic [5:0]          r_s1_b;
  logic                r_s2_valid;
  logic [15:0][13:0]   w_dist;
  logic [15:0][13:0]   r_s2_dist;
  logic [3:0]          w_best_idx;
  logic [13:0]         w_best_dist;
  logic                r_out_valid;
  logic [3:0]          r_video;
  logic                r_exact;
  logic [CNT_W-1:0]    r_miss_count;
  logic                w_miss_hit;

  assign w_en               = !r_out_valid || out_ready;
  assign in_ready           = w_en;
  assign w_unused_green_lsb = green[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_r     <= red;
      r_s1_g     <= green[6:1];
      r_s1_b     <= blue;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_dist
    localparam logic [17:0] P_RGB = pal_rgb(gi);
    logic [5:0]  w_dr, w_dg, w_db;
    logic [11:0] w_sr, w_sg, w_sb;

    assign w_dr = (r_s1_r >= P_RGB[17:12]) ? r_s1_r - P_RGB[17:12] : P_RGB[17:12] - r_s1_r;
    assign w_dg = (r_s1_g >= P_RGB[11:6])  ? r_s1_g - P_RGB[11:6]  : P_RGB[11:6]  - r_s1_g;
    assign w_db = (r_s1_b >= P_RGB[5:0])   ? r_s1_b - P_RGB[5:0]   : P_RGB[5:0]   - r_s1_b;
    assign w_sr = {6'd0, w_dr} * {6'd0, w_dr};
    assign w_sg = {6'd0, w_dg} * {6'd0, w_dg};
    assign w_sb = {6'd0, w_db} * {6'd0, w_db};
    assign w_dist[gi] = {2'd0, w_sr} + {2'd0, w_sg} + {2'd0, w_sb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_dist  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_dist  <= w_dist;
    end
  end

  // Strict less-than scanning upward keeps the lowest index on ties.
  always_comb begin
    w_best_idx  = 4'd0;
    w_best_dist = r_s2_dist[0];
    for (int k = 1; k < 16; k++) begin
      if (r_s2_dist[k] < w_best_dist) begin
        w_best_dist = r_s2_dist[k];
        w_best_idx  = 4'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_video     <= '0;
      r_exact     <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s2_valid;
      r_video     <= w_best_idx;
      r_exact     <= (w_best_dist == 14'd0);
    end
  end

  assign w_miss_hit = r_out_valid && out_ready && !r_exact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_count <= '0;
    end else if (miss_clear) begin
      r_miss_count <= '0;
    end else if (w_miss_hit && (r_miss_count != {CNT_W{1'b1}})) begin
      r_miss_count <= r_miss_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign video      = r_video;
  assign exact      = r_exact;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_cga_rgb_decoder.sv
// Directed bench for cga_rgb_decoder: scoreboard of expected {video, exact} per accepted
// sample, popped at each output handshake; counter and latency checked at directed points.
module tb_cga_rgb_decoder;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       red;
  logic [6:0]       green;
  logic [5:0]       blue;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       video;
  logic             exact;
  logic [CNT_W-1:0] miss_count;
  logic             miss_clear;

  int         total = 0;
  int         bad = 0;
  int         n_out = 0;
  int         exp_miss = 0;
  logic [4:0] sb[$];
  logic [4:0] mon_e;

  int pr[16] = '{0, 0, 0, 0, 42, 42, 42, 42, 21, 21, 21, 21, 63, 63, 63, 63};
  int pg[16] = '{0, 0, 42, 42, 0, 0, 21, 42, 21, 21, 63, 63, 21, 21, 63, 63};
  int pb[16] = '{0, 42, 0, 42, 0, 42, 0, 42, 21, 63, 21, 63, 21, 63, 21, 63};

  always #5 clk = ~clk;

  cga_rgb_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .video      (video),
    .exact      (exact),
    .miss_count (miss_count),
    .miss_clear (miss_clear)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Brute-force nearest palette entry from the level tables; returns {index, exact}.
  function automatic logic [4:0] model(input int r, input int g6, input int b);
    int bd = 1 << 30;
    int bi = 0;
    for (int k = 0; k < 16; k++) begin
      int d;
      d = (r - pr[k]) * (r - pr[k]) + (g6 - pg[k]) * (g6 - pg[k]) + (b - pb[k]) * (b - pb[k]);
      if (d < bd) begin
        bd = d;
        bi = k;
      end
    end
    return {4'(bi), (bd == 0)};
  endfunction

  // Outputs and inputs are stable at the falling edge; a handshake seen here completes
  // at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_miss = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          $display("out #%0d video=%h exact=%b (expect %h/%b)", n_out, video, exact, mon_e[4:1], mon_e[0]);
          chk("video", 32'(video), 32'(mon_e[4:1]));
          chk("exact", 32'(exact), 32'(mon_e[0]));
          if (!miss_clear && !mon_e[0] && exp_miss < CNT_MAX) exp_miss++;
        end
      end
      if (miss_clear) exp_miss = 0;
    end
  end

  task automatic send(input int r, input logic [6:0] g, input int b, input logic [4:0] e);
    bit ok;
    red = 6'(r);
    green = g;
    blue = 6'(b);
    in_valid = 1'b1;
    sb.push_back(e);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendpal(input int k);
    logic [5:0] g6;
    g6 = 6'(pg[k]);
    send(pr[k], {g6, g6[0]}, pb[k], {4'(k), 1'b1});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] g6;
    logic [6:0] g7;
    int n0;
    int rr, bb;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    miss_clear = 1'b0;
    red = '0;
    green = '0;
    blue = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_video", 32'(video), 0);
    chk("rst_exact", 32'(exact), 0);
    chk("rst_miss", 32'(miss_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Exact palette colours back to back; first output in the 4th presentation cycle.
    for (int k = 0; k < 16; k++) begin
      g6 = 6'(pg[k]);
      red = 6'(pr[k]);
      green = {g6, g6[0]};
      blue = 6'(pb[k]);
      in_valid = 1'b1;
      sb.push_back({4'(k), 1'b1});
      @(negedge clk);
      chk("t1_in_ready", 32'(in_ready), 1);
      if (k == 2) chk("lat_cycle2", 32'(out_valid), 0);
      if (k == 3) chk("lat_cycle3", 32'(out_valid), 1);
      @(posedge clk);
      #1;
    end
    idle(6);
    chk("t1_drained", 32'(sb.size()), 0);
    chk("t1_outputs", 32'(n_out), 16);
    chk("t1_miss", 32'(miss_count), 0);

    // Brown exact hit, then HHL which is nearest to brown but not exact.
    send(42, 7'b0101011, 0, {4'h6, 1'b1});
    send(42, 7'b1010101, 0, {4'h6, 1'b0});
    idle(6);
    chk("t2_miss", 32'(miss_count), 1);

    // Equal distance to entries 0 and 1: lower index wins.
    send(0, 7'd0, 21, {4'h0, 1'b0});
    idle(6);
    chk("t3_miss", 32'(miss_count), 2);

    for (int i = 0; i < 6; i++) begin
      rr = int'($urandom_range(0, 63));
      bb = int'($urandom_range(0, 63));
      g7 = 7'($urandom_range(0, 127));
      send(rr, g7, bb, model(rr, int'(g7[6:1]), bb));
    end
    idle(6);
    chk("rand_miss", 32'(miss_count), 32'(exp_miss));

    // Backpressure: 4-cycle stall with a sample waiting at the input.
    n0 = n_out;
    sendpal(1);
    sendpal(3);
    sendpal(5);
    out_ready = 1'b0;
    g6 = 6'(pg[9]);
    red = 6'(pr[9]);
    green = {g6, g6[0]};
    blue = 6'(pb[9]);
    in_valid = 1'b1;
    sb.push_back({4'h9, 1'b1});
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_video_hold", 32'(video), 1);
      chk("bp_exact_hold", 32'(exact), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    sendpal(12);
    idle(6);
    chk("bp_count", 32'(n_out - n0), 5);
    chk("bp_drained", 32'(sb.size()), 0);

    // Saturation after 20 misses, then clear coinciding with a miss handshake.
    for (int i = 0; i < 20; i++) send(1 + (i % 10), 7'd0, 0, {4'h0, 1'b0});
    idle(6);
    chk("sat_value", 32'(miss_count), CNT_MAX);
    chk("sat_model", 32'(miss_count), 32'(exp_miss));
    send(5, 7'd0, 0, {4'h0, 1'b0});
    send(6, 7'd0, 0, {4'h0, 1'b0});
    send(7, 7'd0, 0, {4'h0, 1'b0});
    miss_clear = 1'b1;
    @(negedge clk);
    chk("clr_hs_valid", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    miss_clear = 1'b0;
    chk("clr_wins", 32'(miss_count), 0);
    idle(6);
    chk("after_clr", 32'(miss_count), 2);

    // Reset with three samples in flight.
    sendpal(2);
    sendpal(4);
    sendpal(6);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_miss", 32'(miss_count), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    g6 = 6'(pg[10]);
    red = 6'(pr[10]);
    green = {g6, g6[0]};
    blue = 6'(pb[10]);
    in_valid = 1'b1;
    sb.push_back({4'hA, 1'b1});
    @(negedge clk);
    chk("post_rst_c0", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_c1", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_c2", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_c3", 32'(out_valid), 1);
    idle(6);
    chk("post_rst_drained", 32'(sb.size()), 0);
    chk("post_rst_miss", 32'(miss_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
